// File: rtl/lsb_mem_pkg.sv
// Shared definitions for the data-memory access stage: FSM states, request
// field positions, funct3 encodings and the IO window default.
package lsb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam int OP_VALID_BIT = 4;
    localparam int OP_STORE_BIT = 3;
    localparam int OP_F3_MSB    = 2;
    localparam int OP_F3_LSB    = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam int          IO_SPAN_DEFAULT = 8;

    // Number of bytes moved for a given funct3 (1, 2 or 4).
    function automatic logic [2:0] access_len(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_len = 3'd1;
            2'b01:   access_len = 3'd2;
            default: access_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ls_extend.sv
// Sign/zero extension of little-endian raw bytes to a 32-bit load result.
// Bytes above the access width are ignored.
module ls_extend
    import lsb_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = raw_i;
        case (funct3_i[1:0])
            2'b00: begin
                if (funct3_i[2]) result_o = {24'b0, raw_i[7:0]};
                else             result_o = {{24{raw_i[7]}}, raw_i[7:0]};
            end
            2'b01: begin
                if (funct3_i[2]) result_o = {16'b0, raw_i[15:0]};
                else             result_o = {{16{raw_i[15]}}, raw_i[15:0]};
            end
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsb_mem_unit.sv
// Byte-serial load/store engine between the load/store buffer and the shared
// 8-bit RAM port; owns the RAM bus from grant until the last byte.
module lsb_mem_unit
    import lsb_mem_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          IO_SPAN = IO_SPAN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  oprand,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        flush,
    output logic [1:0]  ready,
    output logic [31:0] mem_data,
    output logic        bus_req,
    input  logic        bus_grant,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  cnt_q;
    logic [31:0] result_q;
    logic [1:0]  ready_q;
    logic [31:0] mem_data_q;
    logic        bus_req_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;

    logic [2:0]  len_d;
    logic [1:0]  last_idx_d;
    logic [2:0]  cnt_inc_d;
    logic [1:0]  prev_idx_d;
    logic [31:0] addr_inc_d;
    logic        io_stall_d;
    logic        req_valid_d;
    logic        req_store_d;
    logic [31:0] load_raw_d;
    logic [31:0] load_ext_d;

    assign len_d       = access_len(funct3_q);
    assign last_idx_d  = len_d[1:0] - 2'd1;
    assign cnt_inc_d   = cnt_q + 3'd1;
    assign prev_idx_d  = cnt_q[1:0] - 2'd1;
    assign addr_inc_d  = addr_q + {29'b0, cnt_inc_d};
    assign req_valid_d = oprand[OP_VALID_BIT];
    assign req_store_d = oprand[OP_STORE_BIT];
    // Offset compare keeps the window test correct even if IO_BASE+IO_SPAN wraps.
    assign io_stall_d  = store_q && ((addr_q - IO_BASE) < 32'(IO_SPAN)) && io_buffer_full;

    // The final byte bypasses result_q so the result is ready on the done edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_raw
            assign load_raw_d[8*gi +: 8] = (last_idx_d == 2'(gi)) ? mem_din
                                                                   : result_q[8*gi +: 8];
        end
    endgenerate

    ls_extend u_extend (
        .funct3_i (funct3_q),
        .raw_i    (load_raw_d),
        .result_o (load_ext_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= 32'b0;
            data_q     <= 32'b0;
            cnt_q      <= 3'b0;
            result_q   <= 32'b0;
            ready_q    <= 2'b01;
            mem_data_q <= 32'b0;
            bus_req_q  <= 1'b0;
            mem_a_q    <= 32'b0;
            mem_dout_q <= 8'b0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    ready_q <= 2'b01;
                    // Stores are already committed, so a flush cannot cancel them.
                    if (req_valid_d && (req_store_d || !flush)) begin
                        store_q   <= req_store_d;
                        funct3_q  <= oprand[OP_F3_MSB:OP_F3_LSB];
                        addr_q    <= addr;
                        data_q    <= data;
                        bus_req_q <= 1'b1;
                        ready_q   <= 2'b00;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush && !store_q) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        ready_q   <= 2'b01;
                    end else if (bus_grant && !io_stall_d) begin
                        mem_a_q    <= addr_q;
                        mem_wr_q   <= store_q;
                        mem_dout_q <= data_q[7:0];
                        cnt_q      <= 3'd0;
                        result_q   <= 32'b0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (flush && !store_q) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        ready_q   <= 2'b01;
                    end else if (store_q) begin
                        if (cnt_q == len_d - 3'd1) begin
                            mem_wr_q   <= 1'b0;
                            ready_q    <= 2'b11;
                            mem_data_q <= 32'b0;
                            bus_req_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q      <= cnt_inc_d;
                            mem_a_q    <= addr_inc_d;
                            mem_dout_q <= data_q[8*cnt_inc_d[1:0] +: 8];
                        end
                    end else begin
                        // Load: address k goes out at count k, its byte returns two edges later.
                        if (cnt_q == len_d) begin
                            ready_q    <= 2'b11;
                            mem_data_q <= load_ext_d;
                            bus_req_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_inc_d;
                            if (cnt_inc_d < len_d) mem_a_q <= addr_inc_d;
                            if (cnt_q != 3'd0) result_q[8*prev_idx_d +: 8] <= mem_din;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                    mem_wr_q  <= 1'b0;
                    ready_q   <= 2'b01;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign mem_data = mem_data_q;
    assign bus_req  = bus_req_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_lsb_mem_unit.sv
// Directed bench for lsb_mem_unit with a one-cycle-latency RAM and a grant
// that follows bus_req whenever grant_en is set.
module tb_lsb_mem_unit;
    import lsb_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  oprand;
    logic [31:0] addr;
    logic [31:0] data;
    logic        flush;
    logic [1:0]  ready;
    logic [31:0] mem_data;
    logic        bus_req;
    logic        bus_grant;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic        grant_en;
    logic [7:0]  ram [0:4095];
    logic [31:0] log_a  [0:31];
    logic        log_wr [0:31];
    logic [7:0]  log_do [0:31];

    int n_tests = 0;
    int n_fail  = 0;

    lsb_mem_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .oprand         (oprand),
        .addr           (addr),
        .data           (data),
        .flush          (flush),
        .ready          (ready),
        .mem_data       (mem_data),
        .bus_req        (bus_req),
        .bus_grant      (bus_grant),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    assign bus_grant = bus_req & grant_en;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic store, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        oprand = {1'b1, store, f3};
        addr   = a;
        data   = d;
        tick();
        oprand = 5'b0;
        $display("[TB] issue store=%0d f3=%b addr=%h data=%h flush=%0d", store, f3, a, d, flush);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            log_a[c]  = mem_a;
            log_wr[c] = mem_wr;
            log_do[c] = mem_dout;
            if (ready[1]) begin
                lat = c;
                break;
            end
        end
        $display("[TB] done after %0d cycles mem_data=%h", lat, mem_data);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [31:0] exp_sw;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        rst = 1'b1; rdy = 1'b1; oprand = 5'b0; addr = 32'b0; data = 32'b0;
        flush = 1'b0; io_buffer_full = 1'b0; grant_en = 1'b1;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h200] = 8'h80;
        ram[12'h210] = 8'h00; ram[12'h211] = 8'h80;

        #12;
        check("rst_ready",    32'(ready),    32'h1);
        check("rst_mem_data", mem_data,      32'h0);
        check("rst_bus_req",  32'(bus_req),  32'h0);
        check("rst_mem_a",    mem_a,         32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr",   32'(mem_wr),   32'h0);
        tick(); rst = 1'b0; tick();

        // LW from 0x100: latency 5 after grant (6 after accept)
        issue(1'b0, F3_LW, 32'h100, 32'h0);
        check("lw_accept_ready", 32'(ready),   32'h0);
        check("lw_accept_req",   32'(bus_req), 32'h1);
        wait_done(lat);
        check("lw_latency", 32'(lat), 32'd6);
        for (int k = 0; k < 4; k++) check("lw_mem_a", log_a[k+1], 32'h100 + 32'(k));
        check("lw_data",  mem_data,     32'h44332211);
        check("lw_ready", 32'(ready),   32'h3);
        check("lw_req_drop", 32'(bus_req), 32'h0);
        tick();
        check("lw_pulse_fall", 32'(ready), 32'h1);

        issue(1'b0, F3_LB, 32'h200, 32'h0);
        wait_done(lat);
        check("lb_latency", 32'(lat), 32'd3);
        check("lb_data", mem_data, 32'hFFFFFF80);
        tick();
        issue(1'b0, F3_LBU, 32'h200, 32'h0);
        wait_done(lat);
        check("lbu_data", mem_data, 32'h00000080);
        tick();
        issue(1'b0, F3_LH, 32'h210, 32'h0);
        wait_done(lat);
        check("lh_latency", 32'(lat), 32'd4);
        check("lh_data", mem_data, 32'hFFFF8000);
        tick();

        // SW: four write cycles, done 4 cycles after grant
        issue(1'b1, F3_SW, 32'h300, 32'hDEADBEEF);
        wait_done(lat);
        check("sw_latency", 32'(lat), 32'd5);
        exp_sw = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check("sw_mem_a",  log_a[k+1],         32'h300 + 32'(k));
            check("sw_mem_wr", 32'(log_wr[k+1]),   32'h1);
            check("sw_dout",   32'(log_do[k+1]),   32'(exp_sw[8*k +: 8]));
        end
        check("sw_wr_off",   32'(log_wr[5]), 32'h0);
        check("sw_mem_data", mem_data,       32'h0);
        tick();
        check("sw_ready_idle", 32'(ready), 32'h1);
        check("sw_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'hDEADBEEF);

        // SB into the IO window stalls while the IO FIFO is full
        io_buffer_full = 1'b1;
        issue(1'b1, F3_SB, 32'h0003_0000, 32'h0000_00A5);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("io_stall_wr", 32'(mem_wr), 32'h0);
        end
        check("io_stall_req", 32'(bus_req), 32'h1);
        io_buffer_full = 1'b0;
        wait_done(lat);
        check("io_latency", 32'(lat), 32'd2);
        check("io_wr",   32'(log_wr[1]), 32'h1);
        check("io_addr", log_a[1],        32'h0003_0000);
        check("io_dout", 32'(log_do[1]),  32'hA5);
        tick();

        // LW flushed during byte 2: aborts without a done pulse
        issue(1'b0, F3_LW, 32'h100, 32'h0);
        tick(); tick(); tick();
        check("lwf_mem_a", mem_a, 32'h102);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("lwf_req",   32'(bus_req), 32'h0);
        check("lwf_ready", 32'(ready),   32'h1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ready[1]) seen = 1'b1;
        end
        check("lwf_no_pulse", 32'(seen), 32'h0);
        $display("[TB] flushed LW aborted");

        // SW with the same flush completes all bytes
        issue(1'b1, F3_SW, 32'h320, 32'h11223344);
        tick(); tick(); tick();
        check("swf_mem_a", mem_a, 32'h322);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("swf_wr",    32'(mem_wr),  32'h1);
        check("swf_addr",  mem_a,        32'h323);
        check("swf_req",   32'(bus_req), 32'h1);
        tick();
        check("swf_ready", 32'(ready), 32'h3);
        tick();
        check("swf_ram", {ram[12'h323], ram[12'h322], ram[12'h321], ram[12'h320]}, 32'h11223344);
        $display("[TB] flushed SW completed");

        // Load presented with flush is dropped at acceptance
        flush = 1'b1;
        issue(1'b0, F3_LW, 32'h100, 32'h0);
        flush = 1'b0;
        check("lwdrop_ready", 32'(ready),   32'h1);
        check("lwdrop_req",   32'(bus_req), 32'h0);

        // rdy=0 freezes mid-transfer
        issue(1'b0, F3_LW, 32'h100, 32'h0);
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        check("frz_mem_a", mem_a,       32'h100);
        check("frz_ready", 32'(ready),  32'h0);
        rdy = 1'b1;
        wait_done(lat);
        check("frz_latency", 32'(lat), 32'd5);
        check("frz_data", mem_data, 32'h44332211);
        tick();

        // Grant held low, then async reset in the middle of a SW
        grant_en = 1'b0;
        issue(1'b1, F3_SW, 32'h340, 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("nogrant_req", 32'(bus_req), 32'h1);
            check("nogrant_wr",  32'(mem_wr),  32'h0);
        end
        grant_en = 1'b1;
        tick(); tick();
        check("rstm_wr_before", 32'(mem_wr), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("rstm_wr",    32'(mem_wr),  32'h0);
        check("rstm_ready", 32'(ready),   32'h1);
        check("rstm_req",   32'(bus_req), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("rstm_after", 32'(ready), 32'h1);
        $display("[TB] async reset mid-SW");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
